// File: rtl/beacon_detector.sv
// rtl/beacon_detector.sv - beacon receiver: sync, glitch filter, half-period measurement, lock FSM
//
// Purpose: samples an asynchronous 1-bit sensor, synchronises and glitch-filters
// it, measures every filtered half-period in clock cycles and tracks lock to the
// expected blink rate.
//
// Ports:
//   clk          detector clock
//   rst          synchronous reset, active high
//   det_en       detector enable; low forces IDLE and holds the run counter
//   sensor_in    asynchronous sensor bit
//   beacon_level filtered, registered sensor level
//   meas_len     last measured half-period length (cycles)
//   meas_valid   one-cycle pulse for a qualified measurement
//   meas_good    measurement within HALF-TOL..HALF+TOL (only with meas_valid)
//   locked       high while in LOCKED
//   loss_count   number of LOCKED exits, saturating
module beacon_detector #(
  parameter int CLK_HZ      = 200_000_000,
  parameter int BLINK_HZ    = 1,
  parameter int TOL_SHIFT   = 3,
  parameter int FILT_LEN    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  localparam int HALF_RAW   = CLK_HZ / (2 * BLINK_HZ),
  localparam int HALF       = (HALF_RAW < 1) ? 1 : HALF_RAW,
  localparam int TOL        = HALF >> TOL_SHIFT,
  localparam int CNT_W      = $clog2(HALF + TOL + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_en,
  input  logic             sensor_in,
  output logic             beacon_level,
  output logic [CNT_W-1:0] meas_len,
  output logic             meas_valid,
  output logic             meas_good,
  output logic             locked,
  output logic [15:0]      loss_count
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [GW-1:0]  LOCK_VAL  = GW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] RUN_SAT = CNT_W'(HALF + TOL + 1);
  localparam logic [CNT_W-1:0] RUN_TO  = CNT_W'(HALF + TOL);
  localparam logic [CNT_W:0] RUN_SAT_X = (CNT_W + 1)'(HALF + TOL + 1);
  localparam logic [CNT_W:0] GOOD_LO   = (CNT_W + 1)'(HALF - TOL);
  localparam logic [CNT_W:0] GOOD_HI   = (CNT_W + 1)'(HALF + TOL);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]       meas_len_q, meas_len_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   meas_good_q, meas_good_d;
  logic [GW-1:0]          good_cnt_q, good_cnt_d;
  state_t                 state_q, state_d;
  logic                   locked_q, locked_d;
  logic [15:0]            loss_q, loss_d;

  logic             synced;
  logic             edge_w;
  logic             timeout;
  logic             meas_ok;
  logic             loss_inc;
  logic [CNT_W:0]   run_inc;
  logic [CNT_W:0]   meas_ext;
  logic [GW-1:0]    good_next;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser and glitch filter run regardless of det_en.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], sensor_in};
    filt_cnt_d = '0;
    level_d    = level_q;
    edge_w     = 1'b0;
    if (synced != level_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        level_d = ~level_q;
        edge_w  = 1'b1;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  // Measurement is clamped so a late edge after saturation still fits CNT_W bits.
  always_comb begin
    run_inc  = {1'b0, run_cnt_q} + (CNT_W + 1)'(1);
    meas_ext = (run_inc > RUN_SAT_X) ? RUN_SAT_X : run_inc;
    meas_ok  = (meas_ext >= GOOD_LO) && (meas_ext <= GOOD_HI);
    timeout  = !edge_w && (run_cnt_q == RUN_TO);
    good_next = good_cnt_q + GW'(1);
  end

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    run_cnt_d    = run_cnt_q;
    meas_len_d   = meas_len_q;
    meas_valid_d = 1'b0;
    meas_good_d  = 1'b0;
    loss_inc     = 1'b0;
    loss_d       = loss_q;

    if (!det_en) begin
      state_d    = ST_IDLE;
      good_cnt_d = '0;
    end else begin
      if (edge_w) begin
        meas_len_d = meas_ext[CNT_W-1:0];
        run_cnt_d  = '0;
      end else if (run_cnt_q != RUN_SAT) begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          // First edge only opens a measurement window.
          if (edge_w) begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = '0;
          end
        end
        ST_ACQUIRE: begin
          if (edge_w) begin
            meas_valid_d = 1'b1;
            meas_good_d  = meas_ok;
            if (meas_ok) begin
              good_cnt_d = good_next;
              if (good_next == LOCK_VAL) state_d = ST_LOCKED;
            end else begin
              good_cnt_d = '0;
            end
          end else if (timeout) begin
            state_d    = ST_IDLE;
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (edge_w) begin
            meas_valid_d = 1'b1;
            meas_good_d  = meas_ok;
            if (!meas_ok) begin
              state_d    = ST_ACQUIRE;
              good_cnt_d = '0;
              loss_inc   = 1'b1;
            end
          end else if (timeout) begin
            state_d    = ST_IDLE;
            good_cnt_d = '0;
            loss_inc   = 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_cnt_d = '0;
        end
      endcase
    end

    if (loss_inc && (loss_q != 16'hFFFF)) loss_d = loss_q + 16'd1;
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      filt_cnt_q   <= '0;
      level_q      <= 1'b0;
      run_cnt_q    <= '0;
      meas_len_q   <= '0;
      meas_valid_q <= 1'b0;
      meas_good_q  <= 1'b0;
      good_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      locked_q     <= 1'b0;
      loss_q       <= '0;
    end else begin
      sync_q       <= sync_d;
      filt_cnt_q   <= filt_cnt_d;
      level_q      <= level_d;
      run_cnt_q    <= run_cnt_d;
      meas_len_q   <= meas_len_d;
      meas_valid_q <= meas_valid_d;
      meas_good_q  <= meas_good_d;
      good_cnt_q   <= good_cnt_d;
      state_q      <= state_d;
      locked_q     <= locked_d;
      loss_q       <= loss_d;
    end
  end

  assign beacon_level = level_q;
  assign meas_len     = meas_len_q;
  assign meas_valid   = meas_valid_q;
  assign meas_good    = meas_good_q;
  assign locked       = locked_q;
  assign loss_count   = loss_q;

endmodule

// File: tb/tb_beacon_detector.sv
// tb/tb_beacon_detector.sv - randomized self-checking bench for beacon_detector
module tb_beacon_detector;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
  localparam int LOCK_COUNT  = 4;
  localparam int HALF        = 50;   // 1000 / (2*10)
  localparam int TOL         = 6;    // 50 >> 3
  localparam int LO          = HALF - TOL;
  localparam int HI          = HALF + TOL;
  localparam int CNT_W       = 6;    // clog2(58)

  logic             clk = 1'b0;
  logic             rst;
  logic             det_en;
  logic             sensor_in;
  logic             beacon_level;
  logic [CNT_W-1:0] meas_len;
  logic             meas_valid;
  logic             meas_good;
  logic             locked;
  logic [15:0]      loss_count;

  beacon_detector #(
    .CLK_HZ(1000), .BLINK_HZ(10), .TOL_SHIFT(3),
    .FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk(clk), .rst(rst), .det_en(det_en), .sensor_in(sensor_in),
    .beacon_level(beacon_level), .meas_len(meas_len), .meas_valid(meas_valid),
    .meas_good(meas_good), .locked(locked), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int hist[$];
  int m_level, m_since, m_run, m_loss, m_len;
  bit m_track, m_locked, m_valid, m_good;
  logic lvl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a filtered edge happens when the last FILT_LEN synced
  // samples all disagree with the current level; timing is by elapsed cycles.
  task model_step();
    bit flip, tmo;
    int meas;
    if (rst) begin
      hist = {};
      repeat (SYNC_STAGES + FILT_LEN) hist.push_back(0);
      m_level = 0; m_since = 0; m_run = 0; m_loss = 0; m_len = 0;
      m_track = 0; m_locked = 0; m_valid = 0; m_good = 0;
      return;
    end
    hist.push_front(int'(sensor_in));
    void'(hist.pop_back());
    flip = 1'b1;
    for (int k = SYNC_STAGES; k < SYNC_STAGES + FILT_LEN; k++)
      if (hist[k] == m_level) flip = 1'b0;
    if (flip) m_level = 1 - m_level;
    m_valid = 0;
    m_good  = 0;
    if (!det_en) begin
      m_track = 0; m_run = 0; m_locked = 0;
      return;
    end
    tmo  = !flip && (m_since == HI);
    meas = 0;
    if (flip) begin
      meas    = (m_since + 1 > HI + 1) ? HI + 1 : m_since + 1;
      m_len   = meas;
      m_since = 0;
    end else if (m_since < HI + 1) begin
      m_since++;
    end
    if (!m_track) begin
      if (flip) begin m_track = 1; m_run = 0; end
    end else if (flip) begin
      m_valid = 1;
      m_good  = (meas >= LO) && (meas <= HI);
      if (m_good) begin
        m_run++;
        if (m_run >= LOCK_COUNT) m_locked = 1;
      end else begin
        if (m_locked && m_loss < 65535) m_loss++;
        m_locked = 0; m_run = 0;
      end
    end else if (tmo) begin
      if (m_locked && m_loss < 65535) m_loss++;
      m_track = 0; m_locked = 0; m_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("beacon_level", beacon_level, m_level);
    check_eq("meas_valid", meas_valid, m_valid);
    check_eq("meas_good", meas_good, m_good);
    check_eq("locked", locked, m_locked);
    check_eq("loss_count", loss_count, m_loss);
    if (m_valid) check_eq("meas_len", meas_len, m_len);
  endtask

  task automatic drive(input logic s, input int n);
    sensor_in = s;
    repeat (n) tick();
  endtask

  task automatic run_half(input int len);
    drive(lvl, len);
    lvl = ~lvl;
  endtask

  initial begin
    int len, gp, gl, loss_base;
    bit glitch, saw;

    // 1: reset with sensor high, then level rises 6 cycles after release
    rst = 1'b1; det_en = 1'b1; sensor_in = 1'b1; lvl = 1'b1;
    repeat (3) tick();
    check_eq("rst_level", beacon_level, 0);
    check_eq("rst_valid", meas_valid, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_loss", loss_count, 0);
    check_eq("rst_len", meas_len, 0);
    rst = 1'b0;
    repeat (5) tick();
    check_eq("level_before_6", beacon_level, 0);
    tick();
    check_eq("level_at_6", beacon_level, 1);
    drive(1'b1, 100);

    // 2: nominal square wave locks after edge 5
    lvl = 1'b0;
    repeat (4) run_half(HALF);
    check_eq("no_lock_after_4", locked, 0);
    run_half(HALF);
    check_eq("lock_after_5", locked, 1);

    // 3: boundary half-periods 44, 56, 43, 57
    run_half(44); run_half(56); run_half(43); run_half(57); run_half(HALF);
    check_eq("unlocked_after_bounds", locked, 0);
    check_eq("loss_after_43", loss_count, 1);
    drive(lvl, 100);

    // 4: 3-cycle glitch rejected, 4-cycle pulse passes
    drive(~lvl, 3);
    drive(lvl, 20);
    check_eq("glitch3_rejected", beacon_level, lvl);
    drive(~lvl, 4);
    saw = 1'b0;
    sensor_in = lvl;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (beacon_level !== lvl) saw = 1'b1;
    end
    check_eq("pulse4_seen", saw, 1);
    check_eq("pulse4_back", beacon_level, lvl);
    drive(lvl, 100);

    // 5: lock, freeze -> timeout, then relock
    lvl = ~lvl;
    repeat (5) run_half(HALF);
    check_eq("lock_t5", locked, 1);
    loss_base = m_loss;
    drive(lvl, 80);
    check_eq("timeout_unlock", locked, 0);
    check_eq("timeout_loss", loss_count, loss_base + 1);
    lvl = ~lvl;
    repeat (5) run_half(HALF);
    check_eq("relock_t5", locked, 1);

    // 6: an over-long half-period breaks lock
    loss_base = m_loss;
    run_half(60);
    run_half(HALF);
    check_eq("long_unlock", locked, 0);
    check_eq("long_loss", loss_count, loss_base + 1);
    repeat (4) run_half(HALF);
    check_eq("relock_t6", locked, 1);

    // det_en low drops lock without counting a loss
    loss_base = m_loss;
    det_en = 1'b0;
    tick();
    check_eq("den_unlock", locked, 0);
    check_eq("den_loss", loss_count, loss_base);
    det_en = 1'b1;
    repeat (6) run_half(HALF);
    check_eq("relock_den", locked, 1);

    // reset while locked clears everything on the next edge
    rst = 1'b1;
    tick();
    check_eq("rst_lock_locked", locked, 0);
    check_eq("rst_lock_loss", loss_count, 0);
    check_eq("rst_lock_level", beacon_level, 0);
    check_eq("rst_lock_valid", meas_valid, 0);
    rst = 1'b0;
    lvl = 1'b0;
    drive(lvl, 10);

    // 7: randomized half-periods, glitches and enable drops
    for (int i = 0; i < 150; i++) begin
      len    = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 70) : $urandom_range(42, 58);
      det_en = ($urandom_range(0, 19) != 0);
      glitch = ($urandom_range(0, 4) == 0);
      gl     = $urandom_range(1, 3);
      gp     = $urandom_range(10, len - 10);
      for (int c = 0; c < len; c++) begin
        sensor_in = (glitch && c >= gp && c < gp + gl) ? ~lvl : lvl;
        tick();
      end
      lvl = ~lvl;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
